tensor_ram_writer: RTL and testbench
====================================

# tensor_ram_writer

Stream-to-RAM write sequencer: accepts output activations (one INT8 per beat) over a valid/ready stream and drives the byte-granular write port of the tensor RAM (`we`/`addr_w`/`din`). It places a rows×cols×chans tensor in HWC order from a base byte address. Each pixel's channel group is padded up to a whole 16-byte word, so the wide read side always fetches word-aligned pixels. It sits between the requantization output and the activation tensor RAM of the next layer.

## Interface
Parameters:
- READ_WIDTH, 128, RAM word width (bits); BYTES_PER_WORD = READ_WIDTH/WRITE_WIDTH.
- WRITE_WIDTH, 8, stream/byte width.
- DEPTH_WORDS, 1024, RAM depth in words; ADDR_W = $clog2(DEPTH_WORDS*BYTES_PER_WORD) (14 at default).
- DIM_W, 8, width of each dimension field.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config; ignored unless IDLE.
- base_addr  in  ADDR_W  byte address of tensor element (0,0,0); must be word-aligned (low log2(BYTES_PER_WORD) bits ignored, treated as 0).
- cfg_rows, cfg_cols, cfg_chans  in  DIM_W each  tensor dimensions.
- in_valid  in  1  stream beat valid.
- in_data  in  WRITE_WIDTH  activation byte.
- in_ready  out  1  stream ready.
- ram_we  out  1  to RAM `we`.
- ram_addr_w  out  ADDR_W  to RAM `addr_w`.
- ram_din  out  WRITE_WIDTH  to RAM `din`.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- oob  out  1  sticky: some computed address ≥ DEPTH_WORDS*BYTES_PER_WORD; cleared on start.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN on start with all dims nonzero. IDLE → DONE on start with any dim zero; no writes occur.
- RUN: in_ready=1. Each handshake (in_valid & in_ready) consumes one byte at coordinate (r,c,ch), ch fastest, then c, then r.
- After the handshake of the final element (r=rows-1, c=cols-1, ch=chans-1): RUN → FLUSH.
- FLUSH lasts one cycle → DONE. DONE lasts one cycle → IDLE.
- Address: chans_pad = ceil(chans/BYTES_PER_WORD)*BYTES_PER_WORD; addr = base + (r*cols + c)*chans_pad + ch.
  - Computed incrementally, no multiplier: pix_base += chans_pad when ch wraps; addr = pix_base + ch.
  - Arithmetic is ADDR_W+1 bits wide. If bit ADDR_W is set or addr ≥ RAM size, oob is set, ram_we is suppressed for that beat, and the beat is still consumed.
- Padding bytes (ch ≥ chans) are never written.
- Config is latched at start; dimension changes mid-job have no effect.
- start during RUN/FLUSH/DONE is ignored.

## Timing
- Reset values: in_ready=0, ram_we=0, ram_addr_w=0, ram_din=0, busy=0, done=0, oob=0, state IDLE, counters 0.
- Write latency: handshake in cycle N → ram_we/ram_addr_w/ram_din registered valid in cycle N+1. Throughput is one byte per cycle.
- ram_we=0 in every cycle with no handshake in the prior cycle.
- busy is high from the cycle after start through the FLUSH cycle, so it covers the final ram_we.
- done is high in the DONE cycle, one cycle after the final ram_we; the RAM write has committed by then.
- in_ready drops in the cycle after the final handshake.
- Zero-dim job: start in cycle S → done in S+1, busy stays 0.
- Reset mid-job: returns immediately to reset values; any pending write is dropped.

## Structure
- Shared package `sys_types` provides BYTES_PER_WORD and the typedef for the FSM state enum (`tw_state_t`).
- One natural sub-module: `hwc_addr_gen`, holding the ch/c/r counters, the pix_base accumulator, last-element detect and oob compare. The top module keeps the FSM, handshake and output registers.

## Test plan
- Basic 2×2×3, base=0: 12 beats with data 0x01..0x0C → writes to addresses 0,1,2,16,17,18,32,33,34,48,49,50 carrying 0x01..0x0C; done once; oob=0.
- Exact-word channels 1×2×16, base=0x40: addresses 0x40..0x5F contiguous; done 1 cycle after the write to 0x5F.
- Backpressure: in_valid toggles randomly on 1×1×20 → exactly 20 writes, addresses 0..19 in order, no duplicates.
- Zero dimension: cfg_cols=0 → no ram_we, done 1 cycle after start, busy never high.
- Overflow: base=16368 (word 1023), dims 1×2×4 → bytes 16368..16371 written; next 4 beats consumed, ram_we suppressed, oob=1 until next start.
- Reset mid-job after 5 of 12 beats → all outputs 0 next cycle. A new start then writes from base again, and oob is clear.

Source files
------------

// File: rtl/sys_types.sv
// Shared types for the activation write path: word geometry and the writer FSM state.
package sys_types;

  localparam int READ_WIDTH_DEF  = 128;
  localparam int WRITE_WIDTH_DEF = 8;
  localparam int BYTES_PER_WORD  = READ_WIDTH_DEF / WRITE_WIDTH_DEF;

  typedef enum logic [1:0] {
    TW_IDLE  = 2'd0,
    TW_RUN   = 2'd1,
    TW_FLUSH = 2'd2,
    TW_DONE  = 2'd3
  } tw_state_t;

endpackage

// File: rtl/tensor_ram_writer_if.sv
// Job control, activation stream and RAM byte-write port of the tensor RAM writer.
interface tensor_ram_writer_if #(
  parameter int ADDR_W      = 14,
  parameter int WRITE_WIDTH = 8,
  parameter int DIM_W       = 8
);
  logic                   start;
  logic [ADDR_W-1:0]      base_addr;
  logic [DIM_W-1:0]       cfg_rows;
  logic [DIM_W-1:0]       cfg_cols;
  logic [DIM_W-1:0]       cfg_chans;
  logic                   in_valid;
  logic [WRITE_WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_addr_w;
  logic [WRITE_WIDTH-1:0] ram_din;
  logic                   busy;
  logic                   done;
  logic                   oob;

  modport master (
    output start, base_addr, cfg_rows, cfg_cols, cfg_chans, in_valid, in_data,
    input  in_ready, ram_we, ram_addr_w, ram_din, busy, done, oob
  );

  modport slave (
    input  start, base_addr, cfg_rows, cfg_cols, cfg_chans, in_valid, in_data,
    output in_ready, ram_we, ram_addr_w, ram_din, busy, done, oob
  );
endinterface

// File: rtl/hwc_addr_gen.sv
// HWC address walker: ch/c/r counters plus a pixel-base accumulator padded to whole RAM words.
module hwc_addr_gen
  import sys_types::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DIM_W     = 8,
  parameter int BPW       = BYTES_PER_WORD,
  parameter int RAM_BYTES = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  chans,
  output logic [ADDR_W:0]   addr,
  output logic              last,
  output logic              addr_oob
);
  localparam logic [ADDR_W:0] PAD_MASK = ~((ADDR_W+1)'(BPW - 1));
  localparam logic [ADDR_W:0] RAM_END  = (ADDR_W+1)'(RAM_BYTES);

  logic [DIM_W-1:0] rows_q, cols_q, chans_q;
  logic [DIM_W-1:0] r, c, ch;
  logic [ADDR_W:0]  pix_base, chans_pad;
  logic             ch_wrap, c_wrap, r_wrap;

  assign ch_wrap  = (ch == chans_q - DIM_W'(1));
  assign c_wrap   = (c  == cols_q  - DIM_W'(1));
  assign r_wrap   = (r  == rows_q  - DIM_W'(1));
  assign last     = ch_wrap & c_wrap & r_wrap;
  assign addr     = pix_base + (ADDR_W+1)'(ch);
  // One spare bit catches wrap past the top of the byte space.
  assign addr_oob = addr[ADDR_W] | (addr >= RAM_END);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q    <= '0;
      cols_q    <= '0;
      chans_q   <= '0;
      r         <= '0;
      c         <= '0;
      ch        <= '0;
      pix_base  <= '0;
      chans_pad <= '0;
    end else if (load) begin
      rows_q    <= rows;
      cols_q    <= cols;
      chans_q   <= chans;
      r         <= '0;
      c         <= '0;
      ch        <= '0;
      chans_pad <= ((ADDR_W+1)'(chans) + (ADDR_W+1)'(BPW - 1)) & PAD_MASK;
      pix_base  <= {1'b0, base & PAD_MASK[ADDR_W-1:0]};
    end else if (advance) begin
      if (ch_wrap) begin
        ch       <= '0;
        pix_base <= pix_base + chans_pad;
        if (c_wrap) begin
          c <= '0;
          r <= r + DIM_W'(1);
        end else begin
          c <= c + DIM_W'(1);
        end
      end else begin
        ch <= ch + DIM_W'(1);
      end
    end
  end
endmodule

// File: rtl/tensor_ram_writer.sv
// Stream-to-RAM write sequencer: places an INT8 HWC tensor into the byte write port of the tensor RAM.
module tensor_ram_writer
  import sys_types::*;
#(
  parameter  int READ_WIDTH  = READ_WIDTH_DEF,
  parameter  int WRITE_WIDTH = WRITE_WIDTH_DEF,
  parameter  int DEPTH_WORDS = 1024,
  parameter  int DIM_W       = 8,
  localparam int BPW         = READ_WIDTH / WRITE_WIDTH,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS * BPW)
) (
  input logic               clk,
  input logic               reset,
  tensor_ram_writer_if.slave bus
);
  tw_state_t       state;
  logic            hs, accept, dims_ok;
  logic [ADDR_W:0] addr;
  logic            last, addr_oob;

  assign hs      = (state == TW_RUN) & bus.in_valid;
  assign accept  = (state == TW_IDLE) & bus.start;
  assign dims_ok = (|bus.cfg_rows) & (|bus.cfg_cols) & (|bus.cfg_chans);

  hwc_addr_gen #(
    .ADDR_W   (ADDR_W),
    .DIM_W    (DIM_W),
    .BPW      (BPW),
    .RAM_BYTES(DEPTH_WORDS * BPW)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (accept & dims_ok),
    .advance (hs),
    .base    (bus.base_addr),
    .rows    (bus.cfg_rows),
    .cols    (bus.cfg_cols),
    .chans   (bus.cfg_chans),
    .addr    (addr),
    .last    (last),
    .addr_oob(addr_oob)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TW_IDLE;
    end else begin
      case (state)
        TW_IDLE:  if (accept) state <= dims_ok ? TW_RUN : TW_DONE;
        TW_RUN:   if (hs && last) state <= TW_FLUSH;
        TW_FLUSH: state <= TW_DONE;
        TW_DONE:  state <= TW_IDLE;
        default:  state <= TW_IDLE;
      endcase
    end
  end

  // Write port is registered one cycle behind the handshake; out-of-range beats are consumed unwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ram_we     <= 1'b0;
      bus.ram_addr_w <= '0;
      bus.ram_din    <= '0;
      bus.oob        <= 1'b0;
    end else begin
      bus.ram_we <= hs & ~addr_oob;
      if (hs) begin
        bus.ram_addr_w <= addr[ADDR_W-1:0];
        bus.ram_din    <= bus.in_data;
      end
      if (accept)             bus.oob <= 1'b0;
      else if (hs & addr_oob) bus.oob <= 1'b1;
    end
  end

  assign bus.in_ready = (state == TW_RUN);
  assign bus.busy     = (state == TW_RUN) | (state == TW_FLUSH);
  assign bus.done     = (state == TW_DONE);
endmodule

// File: tb/tb_tensor_ram_writer.sv
// Directed bench for tensor_ram_writer: HWC placement, padding, backpressure, zero dims, overflow, reset.
module tb_tensor_ram_writer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tensor_ram_writer_if #(.ADDR_W(14), .WRITE_WIDTH(8), .DIM_W(8)) bus ();

  tensor_ram_writer dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cnt;
  int done_cyc;
  bit busy_seen;

  // Monitor: samples outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.ram_we === 1'b1) begin
      wr_addr.push_back(int'(bus.ram_addr_w));
      wr_data.push_back(int'(bus.ram_din));
      wr_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    busy_seen = 1'b0;
  endtask

  task automatic do_start(input int base, input int rows, input int cols, input int chans,
                          output int s_cyc);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 14'(base);
    bus.cfg_rows  = 8'(rows);
    bus.cfg_cols  = 8'(cols);
    bus.cfg_chans = 8'(chans);
    s_cyc = cyc;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cfg_rows  = 8'd7;
    bus.cfg_cols  = 8'd7;
    bus.cfg_chans = 8'd7;
  endtask

  task automatic send(input int n, input int first, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = 8'(first + i);
      if (bus.in_valid && bus.in_ready) i++;
      guard++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (i !== n) begin
      $display("FAIL send_timeout: beats accepted %0d, required %0d", i, n);
      n_fail++;
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done_cnt == 0) begin
      $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", budget);
      n_fail++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.cfg_rows  = '0;
    bus.cfg_cols  = '0;
    bus.cfg_chans = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    repeat (2) @(negedge clk);
    n_checks += 7;
    if (bus.in_ready !== 1'b0)    begin $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); n_fail++; end
    if (bus.ram_we !== 1'b0)      begin $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); n_fail++; end
    if (bus.ram_addr_w !== 14'd0) begin $display("FAIL rst_addr: got %0d want 0", bus.ram_addr_w); n_fail++; end
    if (bus.ram_din !== 8'd0)     begin $display("FAIL rst_din: got %0d want 0", bus.ram_din); n_fail++; end
    if (bus.busy !== 1'b0)        begin $display("FAIL rst_busy: got %b want 0", bus.busy); n_fail++; end
    if (bus.done !== 1'b0)        begin $display("FAIL rst_done: got %b want 0", bus.done); n_fail++; end
    if (bus.oob !== 1'b0)         begin $display("FAIL rst_oob: got %b want 0", bus.oob); n_fail++; end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s;
    int exp_addr;
    clear_log();
    do_start(0, 2, 2, 3, s);
    send(12, 1, 1'b0);
    wait_done(20);
    n_checks += 3;
    if (wr_addr.size() !== 12) begin $display("FAIL basic_count: got %0d writes want 12", wr_addr.size()); n_fail++; end
    if (done_cnt !== 1)        begin $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); n_fail++; end
    if (bus.oob !== 1'b0)      begin $display("FAIL basic_oob: got %b want 0", bus.oob); n_fail++; end
    for (int i = 0; i < 12; i++) begin
      if (i < wr_addr.size()) begin
        exp_addr = (i / 3) * 16 + (i % 3);
        n_checks += 2;
        if (wr_addr[i] !== exp_addr) begin
          $display("FAIL basic_addr[%0d]: got %0d want %0d", i, wr_addr[i], exp_addr); n_fail++;
        end
        if (wr_data[i] !== i + 1) begin
          $display("FAIL basic_data[%0d]: got %0d want %0d", i, wr_data[i], i + 1); n_fail++;
        end
      end
    end
    if (wr_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc !== wr_cyc[wr_cyc.size()-1] + 1) begin
        $display("FAIL basic_done_lat: done cycle %0d want %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        n_fail++;
      end
    end
  endtask

  task automatic test_exact_word();
    int s;
    clear_log();
    do_start('h40, 1, 2, 16, s);
    send(32, 'h20, 1'b0);
    wait_done(20);
    n_checks++;
    if (wr_addr.size() !== 32) begin $display("FAIL word_count: got %0d want 32", wr_addr.size()); n_fail++; end
    for (int i = 0; i < 32; i++) begin
      if (i < wr_addr.size()) begin
        n_checks += 2;
        if (wr_addr[i] !== 'h40 + i) begin
          $display("FAIL word_addr[%0d]: got %0d want %0d", i, wr_addr[i], 'h40 + i); n_fail++;
        end
        if (wr_data[i] !== 'h20 + i) begin
          $display("FAIL word_data[%0d]: got %0d want %0d", i, wr_data[i], 'h20 + i); n_fail++;
        end
      end
    end
    if (wr_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc !== wr_cyc[wr_cyc.size()-1] + 1) begin
        $display("FAIL word_done_lat: done cycle %0d want %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        n_fail++;
      end
    end
  endtask

  task automatic test_backpressure();
    int s;
    clear_log();
    do_start(0, 1, 1, 20, s);
    send(20, 'h80, 1'b1);
    wait_done(20);
    n_checks += 2;
    if (wr_addr.size() !== 20) begin $display("FAIL bp_count: got %0d want 20", wr_addr.size()); n_fail++; end
    if (done_cnt !== 1)        begin $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); n_fail++; end
    for (int i = 0; i < 20; i++) begin
      if (i < wr_addr.size()) begin
        n_checks += 2;
        if (wr_addr[i] !== i) begin
          $display("FAIL bp_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); n_fail++;
        end
        if (wr_data[i] !== 'h80 + i) begin
          $display("FAIL bp_data[%0d]: got %0d want %0d", i, wr_data[i], 'h80 + i); n_fail++;
        end
      end
    end
  endtask

  task automatic test_zero_dim();
    int s;
    clear_log();
    do_start(0, 2, 0, 3, s);
    wait_done(10);
    n_checks += 4;
    if (done_cyc !== s + 1)   begin $display("FAIL zero_done_lat: done cycle %0d want %0d", done_cyc, s + 1); n_fail++; end
    if (wr_addr.size() !== 0) begin $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); n_fail++; end
    if (busy_seen !== 1'b0)   begin $display("FAIL zero_busy: busy seen %b want 0", busy_seen); n_fail++; end
    if (done_cnt !== 1)       begin $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); n_fail++; end
  endtask

  task automatic test_overflow();
    int s;
    clear_log();
    do_start(16368, 1, 2, 4, s);
    send(8, 'h40, 1'b0);
    wait_done(20);
    n_checks += 2;
    if (wr_addr.size() !== 4) begin $display("FAIL ovf_count: got %0d want 4", wr_addr.size()); n_fail++; end
    if (bus.oob !== 1'b1)     begin $display("FAIL ovf_oob: got %b want 1", bus.oob); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr.size()) begin
        n_checks += 2;
        if (wr_addr[i] !== 16368 + i) begin
          $display("FAIL ovf_addr[%0d]: got %0d want %0d", i, wr_addr[i], 16368 + i); n_fail++;
        end
        if (wr_data[i] !== 'h40 + i) begin
          $display("FAIL ovf_data[%0d]: got %0d want %0d", i, wr_data[i], 'h40 + i); n_fail++;
        end
      end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.oob !== 1'b1) begin $display("FAIL ovf_sticky: got %b want 1", bus.oob); n_fail++; end
    clear_log();
    do_start(0, 1, 1, 1, s);
    n_checks++;
    if (bus.oob !== 1'b0) begin $display("FAIL ovf_clear_on_start: got %b want 0", bus.oob); n_fail++; end
    send(1, 'h55, 1'b0);
    wait_done(10);
    n_checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 'h55) begin
      $display("FAIL single_write: got %0d writes, want 1 write of 0x55 at 0", wr_addr.size()); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clear_log();
    do_start('h100, 2, 2, 3, s);
    send(5, 1, 1'b0);
    bus.in_valid = 1'b1;
    reset = 1'b1;
    #1;
    n_checks += 7;
    if (bus.in_ready !== 1'b0)    begin $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); n_fail++; end
    if (bus.ram_we !== 1'b0)      begin $display("FAIL mid_ram_we: got %b want 0", bus.ram_we); n_fail++; end
    if (bus.ram_addr_w !== 14'd0) begin $display("FAIL mid_addr: got %0d want 0", bus.ram_addr_w); n_fail++; end
    if (bus.ram_din !== 8'd0)     begin $display("FAIL mid_din: got %0d want 0", bus.ram_din); n_fail++; end
    if (bus.busy !== 1'b0)        begin $display("FAIL mid_busy: got %b want 0", bus.busy); n_fail++; end
    if (bus.done !== 1'b0)        begin $display("FAIL mid_done: got %b want 0", bus.done); n_fail++; end
    if (bus.oob !== 1'b0)         begin $display("FAIL mid_oob: got %b want 0", bus.oob); n_fail++; end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    do_start('h100, 2, 2, 3, s);
    send(12, 'h30, 1'b0);
    wait_done(20);
    n_checks += 4;
    if (wr_addr.size() !== 12) begin $display("FAIL mid_rerun_count: got %0d want 12", wr_addr.size()); n_fail++; end
    if (wr_addr.size() > 0 && wr_addr[0] !== 'h100) begin
      $display("FAIL mid_rerun_first: got %0d want %0d", wr_addr[0], 'h100); n_fail++;
    end
    if (wr_addr.size() == 12 && wr_addr[11] !== 'h132) begin
      $display("FAIL mid_rerun_last: got %0d want %0d", wr_addr[11], 'h132); n_fail++;
    end
    if (bus.oob !== 1'b0) begin $display("FAIL mid_rerun_oob: got %b want 0", bus.oob); n_fail++; end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_exact_word();
    test_backpressure();
    test_zero_dim();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
